alu_req_arbiter: RTL and testbench

Shares the single 4-bit ALU core between two independent requesters.
- Accepts operation requests (a, b, opcode) over two valid/ready ports and arbitrates round-robin.
- Drives the ALU operand/opcode inputs and a one-cycle eval strobe.
- Captures the latched result and flags, then returns them on a valid/ready response channel tagged with the requester id.
- Sits between the front-end command sources (switch/UART decoders) and the ALU core.

---
 rtl/alu_req_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between two valid/ready requesters.
// Optional per-requester statistics are enabled by defining ALU_ARB_STATS_EN.
module alu_req_arbiter #(
  parameter int DW      = 4,
  parameter int OPW     = 3,
  parameter int NUM_OPS = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_opcode,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_opcode,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_opcode,
  output logic           alu_eval,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_neg,
  input  logic           alu_carry,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_result,
  output logic           rsp_neg,
  output logic           rsp_carry,
  output logic           rsp_zero,
  output logic           rsp_err,
  output logic           busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]     op_count0,
  output logic [7:0]     op_count1,
  output logic [7:0]     err_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [OPW:0] LP_NUM_OPS = (OPW+1)'(NUM_OPS);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_last_grant;
  logic [DW-1:0]  r_alu_a;
  logic [DW-1:0]  r_alu_b;
  logic [OPW-1:0] r_alu_opcode;
  logic           r_id;
  logic [DW-1:0]  r_rsp_result;
  logic           r_rsp_neg;
  logic           r_rsp_carry;
  logic           r_rsp_zero;
  logic           r_rsp_err;

  logic           w_idle;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_accept;
  logic           w_legal;
  logic           w_rsp_hs;
  logic [DW-1:0]  w_sel_a;
  logic [DW-1:0]  w_sel_b;
  logic [OPW-1:0] w_sel_op;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Grant is only offered in IDLE and never while reset is held; on contention
  // the requester that was not served last wins.
  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = w_idle && !rst && req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = w_idle && !rst && req1_valid && (!req0_valid || !r_last_grant);
  assign w_accept = w_grant0 || w_grant1;
  assign w_sel_a  = w_grant1 ? req1_a      : req0_a;
  assign w_sel_b  = w_grant1 ? req1_b      : req0_b;
  assign w_sel_op = w_grant1 ? req1_opcode : req0_opcode;
  assign w_legal  = ({1'b0, w_sel_op} < LP_NUM_OPS);
  assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_opcode = r_alu_opcode;
  assign rsp_id     = r_id;
  assign rsp_result = r_rsp_result;
  assign rsp_neg    = r_rsp_neg;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

  always_comb begin
    w_state_nxt = r_state;
    alu_eval    = 1'b0;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          w_state_nxt = w_legal ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        alu_eval    = 1'b1;
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request acceptance registers the ALU operands; an illegal opcode builds the
  // error response directly and the ALU is never strobed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_id         <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_neg    <= 1'b0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_opcode <= w_sel_op;
        r_id         <= w_grant1;
        r_last_grant <= w_grant1;
        if (!w_legal) begin
          r_rsp_result <= '0;
          r_rsp_neg    <= 1'b0;
          r_rsp_carry  <= 1'b0;
          r_rsp_zero   <= 1'b0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_result <= alu_result;
        r_rsp_neg    <= alu_neg;
        r_rsp_carry  <= alu_carry;
        r_rsp_zero   <= (alu_result == '0);
        r_rsp_err    <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] r_op_count0;
  logic [7:0] r_op_count1;
  logic [7:0] r_err_count;

  assign op_count0 = r_op_count0;
  assign op_count1 = r_op_count1;
  assign err_count = r_err_count;

  // Completed response handshakes; per-requester counts wrap, errors saturate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count0 <= 8'd0;
      r_op_count1 <= 8'd0;
      r_err_count <= 8'd0;
    end else if (w_rsp_hs) begin
      if (r_id) begin
        r_op_count1 <= r_op_count1 + 8'd1;
      end else begin
        r_op_count0 <= r_op_count0 + 8'd1;
      end
      if (r_rsp_err) begin
        r_err_count <= sat_inc8(r_err_count);
      end
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = w_rsp_hs ^ ^sat_inc8(8'd0);
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed plus randomized bench for alu_req_arbiter with a transaction-level
// reference model and a simple behavioural ALU.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_opcode, req1_opcode;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_opcode;
  logic       alu_eval;
  logic [3:0] alu_result;
  logic       alu_neg, alu_carry;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_neg, rsp_carry, rsp_zero, rsp_err, busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] op_count0, op_count1, err_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int exp_last;
  int cnt0, cnt1, errc;

  logic [3:0] t_r;
  logic       t_n, t_c;

  alu_req_arbiter #(.DW(4), .OPW(3), .NUM_OPS(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_opcode(req1_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_eval(alu_eval),
    .alu_result(alu_result), .alu_neg(alu_neg), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
`ifdef ALU_ARB_STATS_EN
    , .op_count0(op_count0), .op_count1(op_count1), .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADD, SUB (magnitude + negative flag), SHR, SHL on 4-bit operands.
  function automatic void alu_ref(input logic [3:0] a, input logic [3:0] b,
                                  input logic [2:0] op, output logic [3:0] r,
                                  output logic n, output logic c);
    logic [4:0] s;
    r = 4'd0; n = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; end
      3'd1: begin
        if (a >= b) r = a - b;
        else begin r = b - a; n = 1'b1; end
      end
      3'd2: r = a >> b;
      3'd3: begin s = {1'b0, a} << b; r = s[3:0]; c = s[4]; end
      default: ;
    endcase
  endfunction

  // Behavioural ALU: latches its result when strobed.
  initial begin alu_result = 4'd0; alu_neg = 1'b0; alu_carry = 1'b0; end
  always @(posedge clk) begin
    if (alu_eval) begin
      alu_ref(alu_a, alu_b, alu_opcode, t_r, t_n, t_c);
      alu_result <= t_r;
      alu_neg    <= t_n;
      alu_carry  <= t_c;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_last = 1; cnt0 = 0; cnt1 = 0; errc = 0;
  endtask

  // One complete transaction starting from IDLE at a falling edge.
  task automatic do_round(input bit v0, input bit v1,
                          input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] op0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] op1,
                          input int hold);
    int win, cyc, evals;
    logic [3:0] ea, eb, er;
    logic [2:0] eop;
    logic en, ec, ee, ez;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_opcode = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_opcode = op1;
    rsp_ready = 1'b0;
    #1;
    if (!v0 && !v1) begin
      chk("idle_ready0", {31'd0, req0_ready}, 0);
      chk("idle_ready1", {31'd0, req1_ready}, 0);
      @(negedge clk);
      return;
    end
    if (v0 && v1) win = (exp_last == 0) ? 1 : 0;
    else          win = v1 ? 1 : 0;
    chk("grant_ready0", {31'd0, req0_ready}, (win == 0) ? 1 : 0);
    chk("grant_ready1", {31'd0, req1_ready}, (win == 1) ? 1 : 0);
    exp_last = win;
    ea  = win ? a1 : a0;
    eb  = win ? b1 : b0;
    eop = win ? op1 : op0;
    ee  = (eop >= 3'd4);
    if (ee) begin er = 4'd0; en = 1'b0; ec = 1'b0; ez = 1'b0; end
    else begin alu_ref(ea, eb, eop, er, en, ec); ez = (er == 4'd0); end

    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("alu_a", {28'd0, alu_a}, {28'd0, ea});
    chk("alu_b", {28'd0, alu_b}, {28'd0, eb});
    chk("alu_opcode", {29'd0, alu_opcode}, {29'd0, eop});
    chk("busy_after_accept", {31'd0, busy}, 1);
    cyc = 1; evals = 0;
    while (!rsp_valid && cyc < 8) begin
      evals += int'(alu_eval);
      @(negedge clk);
      cyc++;
    end
    chk("rsp_latency", cyc, ee ? 1 : 3);
    chk("eval_pulses", evals, ee ? 0 : 1);
    chk("rsp_valid", {31'd0, rsp_valid}, 1);
    chk("rsp_id", {31'd0, rsp_id}, win);
    chk("rsp_result", {28'd0, rsp_result}, {28'd0, er});
    chk("rsp_neg", {31'd0, rsp_neg}, {31'd0, en});
    chk("rsp_carry", {31'd0, rsp_carry}, {31'd0, ec});
    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, ez});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, ee});

    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk("hold_ready0", {31'd0, req0_ready}, 0);
      chk("hold_ready1", {31'd0, req1_ready}, 0);
      chk("hold_valid", {31'd0, rsp_valid}, 1);
      chk("hold_result", {28'd0, rsp_result}, {28'd0, er});
      chk("hold_busy", {31'd0, busy}, 1);
      @(negedge clk);
    end
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    chk("hs_ready0", {31'd0, req0_ready}, 0);
    chk("hs_ready1", {31'd0, req1_ready}, 0);
    @(negedge clk);
    chk("post_hs_valid", {31'd0, rsp_valid}, 0);
    chk("post_hs_busy", {31'd0, busy}, 0);
    chk("alu_a_retained", {28'd0, alu_a}, {28'd0, ea});
    if (win == 1) cnt1 = (cnt1 + 1) % 256;
    else          cnt0 = (cnt0 + 1) % 256;
    if (ee && errc < 255) errc++;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd1; req0_opcode = 3'd0;
    req1_valid = 1'b1; req1_a = 4'd2; req1_b = 4'd2; req1_opcode = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ready0", {31'd0, req0_ready}, 0);
    chk("rst_ready1", {31'd0, req1_ready}, 0);
    chk("rst_eval", {31'd0, alu_eval}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_alu_a", {28'd0, alu_a}, 0);
    chk("rst_rsp_result", {28'd0, rsp_result}, 0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Contention from reset: req0, then req1, then req0 again.
    do_round(1, 1, 4'd2, 4'd7, 3'd1, 4'd9, 4'd9, 3'd0, 0);
    do_round(1, 1, 4'd2, 4'd7, 3'd1, 4'd9, 4'd9, 3'd0, 0);
    do_round(1, 1, 4'd1, 4'd1, 3'd0, 4'd3, 4'd3, 3'd0, 0);
    // Single requester ADD 5+3.
    do_round(1, 0, 4'd5, 4'd3, 3'd0, 4'd0, 4'd0, 3'd0, 0);
    // Illegal opcode from requester 1.
    do_round(0, 1, 4'd0, 4'd0, 3'd0, 4'd4, 4'd2, 3'd6, 0);
    // Zero result under long back-pressure.
    do_round(1, 0, 4'd8, 4'd1, 3'd3, 4'd0, 4'd0, 3'd0, 10);

    // Reset while the ALU is being strobed.
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd4; req0_opcode = 3'd0;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_eval", {31'd0, alu_eval}, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_eval", {31'd0, alu_eval}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 0);
    req1_valid = 1'b1;
    #1;
    chk("mid_rst_ready0", {31'd0, req0_ready}, 0);
    chk("mid_rst_ready1", {31'd0, req1_ready}, 0);
    @(negedge clk);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {31'd0, rsp_valid}, 0);
      chk("post_rst_eval", {31'd0, alu_eval}, 0);
    end
    do_round(1, 1, 4'd6, 4'd2, 3'd2, 4'd7, 4'd1, 3'd3, 1);

    // Randomized traffic, including illegal opcodes and back-pressure.
    for (int r = 0; r < 40; r++) begin
      do_round(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom), 4'($urandom), 3'($urandom),
               4'($urandom), 4'($urandom), 3'($urandom),
               $urandom_range(0, 3));
    end

`ifdef ALU_ARB_STATS_EN
    chk("stat_op_count0", {24'd0, op_count0}, cnt0);
    chk("stat_op_count1", {24'd0, op_count1}, cnt1);
    chk("stat_err_count", {24'd0, err_count}, errc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int r = 0; r < 256; r++) begin
      do_round(1, 0, 4'($urandom), 4'($urandom), 3'($urandom_range(0, 3)),
               4'd0, 4'd0, 3'd0, 0);
    end
    chk("stat_wrap0", {24'd0, op_count0}, 0);
    for (int r = 0; r < 3; r++) begin
      do_round(1, 0, 4'd1, 4'd2, 3'd7, 4'd0, 4'd0, 3'd0, 0);
    end
    chk("stat_err3", {24'd0, err_count}, 3);
    chk("stat_op0_after_err", {24'd0, op_count0}, cnt0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
